sram_responder: RTL and testbench

Memory-side responder for the tester's bus master, which issues address/byteenable/read/write/writedata and expects waitrequest/readdata/readdataready back. It accepts one transaction at a time, runs the timing sequence for an external asynchronous 16-bit SRAM (CE/OE/WE/UB/LB strobes, split data bus), and returns read data with a one-cycle readdataready pulse. It sits between the test controller's memory port and the board SRAM pins, in the same clock domain as the controller.

---
 rtl/tester_pkg.sv | 15 +
 rtl/sram_responder.sv | 159 +++++++++++++++
 tb/tb_sram_responder.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/tester_pkg.sv
// Shared constants for the tester memory path: responder state encoding,
// default SRAM strobe timing and the wait-counter width.
package tester_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_RD       = 3'd1;
  localparam logic [2:0] ST_WR_SETUP = 3'd2;
  localparam logic [2:0] ST_WR_PULSE = 3'd3;
  localparam logic [2:0] ST_WR_HOLD  = 3'd4;

  localparam int DEF_RD_CYCLES = 2;
  localparam int DEF_WR_CYCLES = 2;
  localparam int CNT_WIDTH     = 4;

endpackage

// File: rtl/sram_responder.sv
// Bus-slave front end for an asynchronous 16-bit SRAM: accepts one read or
// write at a time and sequences registered CE/OE/WE/UB/LB strobes.
module sram_responder
  import tester_pkg::*;
#(
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 16,
  parameter int BE_WIDTH   = DATA_WIDTH / 8,
  parameter int RD_CYCLES  = DEF_RD_CYCLES,
  parameter int WR_CYCLES  = DEF_WR_CYCLES
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [BE_WIDTH-1:0]   byteenable,
  input  logic                  read,
  input  logic                  write,
  input  logic [DATA_WIDTH-1:0] writedata,
  output logic                  waitrequest,
  output logic [DATA_WIDTH-1:0] readdata,
  output logic                  readdataready,
  output logic                  protocol_error,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [15:0]           sram_dq_out,
  output logic                  sram_dq_oe,
  input  logic [15:0]           sram_dq_in,
  output logic                  sram_ce_n,
  output logic                  sram_oe_n,
  output logic                  sram_we_n,
  output logic                  sram_ub_n,
  output logic                  sram_lb_n
);

  localparam logic [CNT_WIDTH-1:0] RD_LOAD = CNT_WIDTH'(RD_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] WR_LOAD = CNT_WIDTH'(WR_CYCLES - 1);

  logic [2:0]            state_q,  state_d;
  logic [CNT_WIDTH-1:0]  cnt_q,    cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q,   addr_d;
  logic [BE_WIDTH-1:0]   be_q,     be_d;
  logic [DATA_WIDTH-1:0] wdata_q,  wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q,  rdata_d;
  logic                  rdv_q,    rdv_d;
  logic                  perr_q,   perr_d;
  logic                  ce_n_q,   ce_n_d;
  logic                  oe_n_q,   oe_n_d;
  logic                  we_n_q,   we_n_d;
  logic                  ub_n_q,   ub_n_d;
  logic                  lb_n_q,   lb_n_d;
  logic                  dq_oe_q,  dq_oe_d;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    rdv_d   = 1'b0;
    perr_d  = perr_q;

    case (state_q)
      ST_IDLE: begin
        if (read || write) begin
          addr_d  = address;
          be_d    = byteenable;
          wdata_d = writedata;
          // A simultaneous read+write is flagged and serviced as a write.
          if (read && write) perr_d = 1'b1;
          if (write) begin
            state_d = ST_WR_SETUP;
          end else begin
            state_d = ST_RD;
            cnt_d   = RD_LOAD;
          end
        end
      end
      ST_RD: begin
        if (cnt_q == '0) begin
          rdata_d[15:8] = be_q[1] ? sram_dq_in[15:8] : 8'h00;
          rdata_d[7:0]  = be_q[0] ? sram_dq_in[7:0]  : 8'h00;
          rdv_d         = 1'b1;
          state_d       = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_WR_SETUP: begin
        state_d = ST_WR_PULSE;
        cnt_d   = WR_LOAD;
      end
      ST_WR_PULSE: begin
        if (cnt_q == '0) state_d = ST_WR_HOLD;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_WR_HOLD: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase

    // Pin strobes are decoded from the next state so they change on the same edge as the state.
    ce_n_d  = (state_d == ST_IDLE);
    oe_n_d  = (state_d != ST_RD);
    we_n_d  = (state_d != ST_WR_PULSE);
    ub_n_d  = (state_d == ST_IDLE) || !be_d[1];
    lb_n_d  = (state_d == ST_IDLE) || !be_d[0];
    dq_oe_d = (state_d == ST_WR_SETUP) || (state_d == ST_WR_PULSE) ||
              (state_d == ST_WR_HOLD);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rdv_q   <= 1'b0;
      perr_q  <= 1'b0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      ub_n_q  <= 1'b1;
      lb_n_q  <= 1'b1;
      dq_oe_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      rdv_q   <= rdv_d;
      perr_q  <= perr_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      ub_n_q  <= ub_n_d;
      lb_n_q  <= lb_n_d;
      dq_oe_q <= dq_oe_d;
    end
  end

  assign waitrequest    = (state_q != ST_IDLE);
  assign readdata       = rdata_q;
  assign readdataready  = rdv_q;
  assign protocol_error = perr_q;
  assign sram_addr      = addr_q;
  assign sram_dq_out    = wdata_q;
  assign sram_dq_oe     = dq_oe_q;
  assign sram_ce_n      = ce_n_q;
  assign sram_oe_n      = oe_n_q;
  assign sram_we_n      = we_n_q;
  assign sram_ub_n      = ub_n_q;
  assign sram_lb_n      = lb_n_q;

endmodule

// File: tb/tb_sram_responder.sv
// Bench for sram_responder: default-timing and limit-timing instances, each
// on its own behavioural SRAM, with a read-response scoreboard.
module tb_sram_responder;

  function automatic int rd_cyc(input int d);
    return (d == 0) ? 2 : 1;
  endfunction

  logic        clk;
  logic        rst     [2];
  logic        rd      [2];
  logic        wr      [2];
  logic [19:0] addr    [2];
  logic [1:0]  be      [2];
  logic [15:0] wdata   [2];
  logic        waitreq [2];
  logic [15:0] rdata   [2];
  logic        rdv     [2];
  logic        perr    [2];
  logic [19:0] s_addr  [2];
  logic [15:0] dq_out  [2];
  logic        dq_oe   [2];
  logic [15:0] dq_in   [2];
  logic        ce_n    [2];
  logic        oe_n    [2];
  logic        we_n    [2];
  logic        ub_n    [2];
  logic        lb_n    [2];

  logic [15:0] mem [2][1024];

  int cyc      = 0;
  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    int          dut;
    logic [15:0] data;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  sram_responder #(.RD_CYCLES(2), .WR_CYCLES(2)) u_dut (
    .clock(clk), .reset(rst[0]), .address(addr[0]), .byteenable(be[0]),
    .read(rd[0]), .write(wr[0]), .writedata(wdata[0]),
    .waitrequest(waitreq[0]), .readdata(rdata[0]), .readdataready(rdv[0]),
    .protocol_error(perr[0]), .sram_addr(s_addr[0]), .sram_dq_out(dq_out[0]),
    .sram_dq_oe(dq_oe[0]), .sram_dq_in(dq_in[0]), .sram_ce_n(ce_n[0]),
    .sram_oe_n(oe_n[0]), .sram_we_n(we_n[0]), .sram_ub_n(ub_n[0]), .sram_lb_n(lb_n[0])
  );

  sram_responder #(.RD_CYCLES(1), .WR_CYCLES(15)) u_lim (
    .clock(clk), .reset(rst[1]), .address(addr[1]), .byteenable(be[1]),
    .read(rd[1]), .write(wr[1]), .writedata(wdata[1]),
    .waitrequest(waitreq[1]), .readdata(rdata[1]), .readdataready(rdv[1]),
    .protocol_error(perr[1]), .sram_addr(s_addr[1]), .sram_dq_out(dq_out[1]),
    .sram_dq_oe(dq_oe[1]), .sram_dq_in(dq_in[1]), .sram_ce_n(ce_n[1]),
    .sram_oe_n(oe_n[1]), .sram_we_n(we_n[1]), .sram_ub_n(ub_n[1]), .sram_lb_n(lb_n[1])
  );

  // SRAM read port: junk on the bus unless the chip is selected and output-enabled.
  assign dq_in[0] = (!ce_n[0] && !oe_n[0]) ? mem[0][s_addr[0][9:0]] : 16'hDEAD;
  assign dq_in[1] = (!ce_n[1] && !oe_n[1]) ? mem[1][s_addr[1][9:0]] : 16'hDEAD;

  // SRAM write: a write lands only when WE rises while CE is still low.
  logic        we_prev [2];
  logic [19:0] p_addr  [2];
  logic [15:0] p_data  [2];
  logic        p_ub    [2];
  logic        p_lb    [2];

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!ce_n[d] && !we_n[d]) begin
        p_addr[d] = s_addr[d];
        p_data[d] = dq_oe[d] ? dq_out[d] : 16'hBAD0;
        p_ub[d]   = !ub_n[d];
        p_lb[d]   = !lb_n[d];
      end
      if (we_prev[d] === 1'b0 && we_n[d] === 1'b1 && ce_n[d] === 1'b0) begin
        if (p_ub[d]) mem[d][p_addr[d][9:0]][15:8] = p_data[d][15:8];
        if (p_lb[d]) mem[d][p_addr[d][9:0]][7:0]  = p_data[d][7:0];
      end
      we_prev[d] = we_n[d];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Read-response monitor: every readdataready pulse must match the oldest expectation.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rdv[d] === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_readdataready", 32'(rdv[d]), 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("rd_instance", d, e.dut);
          check("rd_data", 32'(rdata[d]), 32'(e.data));
          check("rd_cycle", cyc, e.cyc);
        end
      end
    end
  end

  // Present a request at a falling edge; returns after the accepting edge.
  task automatic issue(input int d, input logic r, input logic w, input logic [19:0] a,
                       input logic [1:0] b, input logic [15:0] wd,
                       input logic [15:0] exp_rd, output int acc);
    int guard;
    guard = 0;
    rd[d] = r; wr[d] = w; addr[d] = a; be[d] = b; wdata[d] = wd;
    while (waitreq[d] && guard < 64) begin
      @(negedge clk);
      guard++;
    end
    if (waitreq[d]) check("accept_timeout", 32'(waitreq[d]), 32'd0);
    acc = cyc + 1;
    if (r && !w) sb.push_back('{dut: d, data: exp_rd, cyc: acc + rd_cyc(d)});
    @(negedge clk);
    rd[d] = 1'b0;
    wr[d] = 1'b0;
  endtask

  // Count busy cycles and active strobes until the responder is idle again.
  task automatic measure(input int d, output int busy, output int oe_lo, output int we_lo,
                         output int ub_lo, output int lb_lo);
    busy = 0; oe_lo = 0; we_lo = 0; ub_lo = 0; lb_lo = 0;
    while (waitreq[d] && busy < 64) begin
      busy++;
      if (!oe_n[d]) oe_lo++;
      if (!we_n[d]) we_lo++;
      if (!ub_n[d]) ub_lo++;
      if (!lb_n[d]) lb_lo++;
      @(negedge clk);
    end
    if (waitreq[d]) check("busy_timeout", 32'(waitreq[d]), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int acc, acc_prev, busy, oe_lo, we_lo, ub_lo, lb_lo;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; rd[d] = 1'b0; wr[d] = 1'b0; addr[d] = '0; be[d] = '0; wdata[d] = '0;
      we_prev[d] = 1'b1; p_ub[d] = 1'b0; p_lb[d] = 1'b0; p_addr[d] = '0; p_data[d] = '0;
      for (int i = 0; i < 1024; i++) mem[d][i] = 16'h0000;
    end
    mem[0][20'h123] = 16'hBEEF;
    mem[0][20'h010] = 16'hFFFF;
    mem[0][0] = 16'h1111; mem[0][1] = 16'h2222; mem[0][2] = 16'h3333; mem[0][3] = 16'h4444;
    mem[0][20'h030] = 16'h1357;
    mem[1][20'h020] = 16'hC3A5;
    mem[1][20'h022] = 16'h7777;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_waitrequest", 32'(waitreq[0]), 32'd0);
    check("rst_readdataready", 32'(rdv[0]), 32'd0);
    check("rst_readdata", 32'(rdata[0]), 32'd0);
    check("rst_protocol_error", 32'(perr[0]), 32'd0);
    check("rst_strobes", 32'({ce_n[0], oe_n[0], we_n[0], ub_n[0], lb_n[0], dq_oe[0]}), 32'b111110);
    check("rst_sram_addr", 32'(s_addr[0]), 32'd0);
    check("rst_dq_out", 32'(dq_out[0]), 32'd0);
    check("rst_strobes_lim", 32'({ce_n[1], oe_n[1], we_n[1], ub_n[1], lb_n[1], dq_oe[1]}), 32'b111110);
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    @(negedge clk);

    // Single read
    issue(0, 1'b1, 1'b0, 20'h00123, 2'b11, 16'h0, 16'hBEEF, acc);
    measure(0, busy, oe_lo, we_lo, ub_lo, lb_lo);
    check("rd_busy", busy, 2);
    check("rd_oe_low", oe_lo, 2);
    check("rd_we_low", we_lo, 0);

    // Low-byte write over 0xFFFF
    issue(0, 1'b0, 1'b1, 20'h00010, 2'b01, 16'hA55A, 16'h0, acc);
    measure(0, busy, oe_lo, we_lo, ub_lo, lb_lo);
    check("bw_busy", busy, 4);
    check("bw_we_low", we_lo, 2);
    check("bw_oe_low", oe_lo, 0);
    check("bw_ub_low", ub_lo, 0);
    check("bw_lb_low", lb_lo, 4);
    check("bw_mem", 32'(mem[0][20'h010]), 32'hFF5A);

    // Back-to-back reads with read held high
    acc_prev = 0;
    for (int i = 0; i < 4; i++) begin
      issue(0, 1'b1, 1'b0, 20'(i), 2'b11, 16'h0, 16'(16'h1111 * (i + 1)), acc);
      if (i > 0) check("b2b_spacing", acc - acc_prev, 3);
      acc_prev = acc;
    end
    measure(0, busy, oe_lo, we_lo, ub_lo, lb_lo);

    // Read/write collision
    issue(0, 1'b1, 1'b1, 20'h00005, 2'b11, 16'h1234, 16'h0, acc);
    measure(0, busy, oe_lo, we_lo, ub_lo, lb_lo);
    check("col_busy", busy, 4);
    check("col_we_low", we_lo, 2);
    check("col_mem", 32'(mem[0][5]), 32'h1234);
    check("col_protocol_error", 32'(perr[0]), 32'd1);
    issue(0, 1'b1, 1'b0, 20'h00123, 2'b10, 16'h0, 16'hBE00, acc);
    measure(0, busy, oe_lo, we_lo, ub_lo, lb_lo);
    check("perr_sticky", 32'(perr[0]), 32'd1);

    // Reset during the write pulse
    issue(0, 1'b0, 1'b1, 20'h00030, 2'b11, 16'h0F0F, 16'h0, acc);
    @(negedge clk);
    check("pre_rst_we_n", 32'(we_n[0]), 32'd0);
    rst[0] = 1'b1;
    @(negedge clk);
    check("midrst_we_n", 32'(we_n[0]), 32'd1);
    check("midrst_dq_oe", 32'(dq_oe[0]), 32'd0);
    check("midrst_waitrequest", 32'(waitreq[0]), 32'd0);
    check("midrst_protocol_error", 32'(perr[0]), 32'd0);
    @(negedge clk);
    rst[0] = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_mem", 32'(mem[0][20'h030]), 32'h1357);

    // Limit timing instance: RD_CYCLES=1, WR_CYCLES=15
    issue(1, 1'b1, 1'b0, 20'h00020, 2'b10, 16'h0, 16'hC300, acc);
    measure(1, busy, oe_lo, we_lo, ub_lo, lb_lo);
    check("lim_rd_busy", busy, 1);
    check("lim_rd_oe_low", oe_lo, 1);
    issue(1, 1'b0, 1'b1, 20'h00021, 2'b11, 16'h5A5A, 16'h0, acc);
    measure(1, busy, oe_lo, we_lo, ub_lo, lb_lo);
    check("lim_wr_busy", busy, 17);
    check("lim_wr_we_low", we_lo, 15);
    check("lim_wr_mem", 32'(mem[1][20'h021]), 32'h5A5A);
    issue(1, 1'b0, 1'b1, 20'h00022, 2'b00, 16'h0000, 16'h0, acc);
    measure(1, busy, oe_lo, we_lo, ub_lo, lb_lo);
    check("be0_busy", busy, 17);
    check("be0_lanes_low", ub_lo + lb_lo, 0);
    check("be0_mem", 32'(mem[1][20'h022]), 32'h7777);
    check("be0_idle", 32'(waitreq[1]), 32'd0);

    repeat (4) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
